// File: rtl/baud_rate_gen.sv
// Baud tick generator: oversample, mid-bit and bit ticks from one shadow-loaded divisor.
// Define BAUD_FRAC_EN to build the fractional-divisor accumulator; otherwise the period is exactly div_int.
module baud_rate_gen #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_sync_clear,
  input  logic [DIV_W-1:0]        i_div_int,
  input  logic [FRAC_W-1:0]       i_div_frac,
  input  logic                    i_div_load,
  output logic                    o_div_pending,
  output logic                    o_os_tick,
  output logic                    o_mid_tick,
  output logic                    o_bit_tick,
  output logic [$clog2(OVS)-1:0]  o_os_phase
);
  localparam int PW = $clog2(OVS);
  localparam logic [PW-1:0] PH_LAST = PW'(OVS - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVS / 2);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_int;
  logic [DIV_W-1:0] r_sh_int;
  logic             r_pending;
  logic [PW-1:0]    r_phase;
  logic             r_os_tick;
  logic             r_mid_tick;
  logic             r_bit_tick;

  logic             w_run;
  logic             w_last;
  logic             w_wrap;
  logic             w_apply;
  logic [PW-1:0]    w_ph_next;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_div_frac;
  logic [FRAC_W-1:0] r_sh_frac;
  logic [FRAC_W-1:0] r_acc;
  logic              r_ext;
  logic [FRAC_W:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_div_frac};
  // With extend set the period is div_int+1, so its last count equals div_int.
  assign w_last = (r_cnt == (r_ext ? r_div_int : r_div_int - DIV_W'(1)));
`else
  logic w_unused_frac;

  assign w_unused_frac = &{1'b0, i_div_frac};
  assign w_last        = (r_cnt == r_div_int - DIV_W'(1));
`endif

  assign w_run     = i_enable && (r_div_int != '0);
  assign w_wrap    = w_run && w_last;
  assign w_apply   = r_pending && (w_wrap || i_sync_clear);
  assign w_ph_next = (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_div_int  <= DIV_W'(DEFAULT_DIV);
      r_sh_int   <= DIV_W'(DEFAULT_DIV);
      r_pending  <= 1'b0;
      r_phase    <= '0;
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
`ifdef BAUD_FRAC_EN
      r_div_frac <= '0;
      r_sh_frac  <= '0;
      r_acc      <= '0;
      r_ext      <= 1'b0;
`endif
    end else begin
      r_os_tick  <= 1'b0;
      r_mid_tick <= 1'b0;
      r_bit_tick <= 1'b0;
      if (i_sync_clear) begin
        r_cnt   <= '0;
        r_phase <= '0;
`ifdef BAUD_FRAC_EN
        r_acc   <= '0;
        r_ext   <= 1'b0;
`endif
      end else if (w_wrap) begin
        r_cnt      <= '0;
        r_phase    <= w_ph_next;
        r_os_tick  <= 1'b1;
        r_mid_tick <= (w_ph_next == PH_MID);
        r_bit_tick <= (w_ph_next == '0);
`ifdef BAUD_FRAC_EN
        if (w_apply) begin
          r_acc <= '0;
          r_ext <= 1'b0;
        end else begin
          r_acc <= w_sum[FRAC_W-1:0];
          r_ext <= w_sum[FRAC_W];
        end
`endif
      end else if (w_run) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end

      if (w_apply) begin
        r_div_int <= r_sh_int;
`ifdef BAUD_FRAC_EN
        r_div_frac <= r_sh_frac;
`endif
        r_pending <= 1'b0;
      end
      // A load on the apply edge re-arms pending, deferring to the next wrap.
      if (i_div_load) begin
        r_sh_int  <= i_div_int;
`ifdef BAUD_FRAC_EN
        r_sh_frac <= i_div_frac;
`endif
        r_pending <= 1'b1;
      end
    end
  end

  assign o_div_pending = r_pending;
  assign o_os_tick     = r_os_tick;
  assign o_mid_tick    = r_mid_tick;
  assign o_bit_tick    = r_bit_tick;
  assign o_os_phase    = r_phase;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen; expected tick times come from closed-form period arithmetic.
module tb_baud_rate_gen;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int DEF    = 27;
  localparam int PW     = $clog2(OVS);
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              sync_clear = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              div_pending;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic [PW-1:0]     os_phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  baud_rate_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEFAULT_DIV(DEF)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_sync_clear(sync_clear),
    .i_div_int(div_int), .i_div_frac(div_frac), .i_div_load(div_load),
    .o_div_pending(div_pending), .o_os_tick(os_tick), .o_mid_tick(mid_tick),
    .o_bit_tick(bit_tick), .o_os_phase(os_phase)
  );

  wire [PW+2:0] obs = {os_tick, mid_tick, bit_tick, os_phase};

  // Edge count (since clear) at which the k-th os_tick becomes visible.
  function automatic int tick_time(int k, int d, int f);
    return k * d + (((k - 1) * f) >> FRAC_W);
  endfunction

  function automatic logic [PW+2:0] pack_exp(bit tk, int p);
    return {tk, tk && (p == OVS / 2), tk && (p == 0), PW'(p)};
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int d, input int f);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    tick_edge();
    div_load = 1'b0;
  endtask

  task automatic do_clear();
    sync_clear = 1'b1;
    tick_edge();
    sync_clear = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    bit tk;
    logic [PW+2:0] e;
    reset = 1'b1; enable = 1'b1; div_int = 5; div_load = 1'b1; sync_clear = 1'b1;
    tick_edge();
    tick_edge();
    div_load = 1'b0; sync_clear = 1'b0;
    total++;
    if (obs !== pack_exp(0, 0) || div_pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%b/%b want=%b/0", obs, div_pending, pack_exp(0, 0));
    end
    reset = 1'b0;
    k = 1;
    for (int t = 1; t <= 440; t++) begin
      tick_edge();
      tk = (t == k * DEF);
      e  = pack_exp(tk, tk ? k % OVS : (k - 1) % OVS);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL default_div t=%0d got=%b want=%b", t, obs, e);
      end
      if (tk) k++;
    end
  endtask

  task automatic test_load_clear();
    int k;
    bit tk;
    logic [PW+2:0] e;
    do_load(10, 0);
    total++;
    if (div_pending !== 1'b1) begin
      bad++;
      $display("FAIL load_pending got=%b want=1", div_pending);
    end
    do_clear();
    total++;
    if (obs !== pack_exp(0, 0) || div_pending !== 1'b0) begin
      bad++;
      $display("FAIL clear_apply got=%b/%b want=%b/0", obs, div_pending, pack_exp(0, 0));
    end
    k = 1;
    for (int t = 1; t <= 170; t++) begin
      tick_edge();
      tk = (t == 10 * k);
      e  = pack_exp(tk, tk ? k % OVS : (k - 1) % OVS);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL div10 t=%0d got=%b want=%b", t, obs, e);
      end
      if (tk) k++;
    end
  endtask

  task automatic test_frac();
    int k, fe, t1, t17;
    bit tk;
    logic [PW+2:0] e;
    fe = FRAC_ON ? 8 : 0;
    t1 = 0; t17 = 0;
    do_load(10, 8);
    do_clear();
    k = 1;
    for (int t = 1; t <= 185; t++) begin
      tick_edge();
      tk = (t == tick_time(k, 10, fe));
      e  = pack_exp(tk, tk ? k % OVS : (k - 1) % OVS);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL frac t=%0d got=%b want=%b", t, obs, e);
      end
      if (os_tick === 1'b1) begin
        if (t1 == 0) t1 = t;
        else if (t17 == 0 && os_phase == PW'(17 % OVS) && t - t1 > 100) t17 = t;
      end
      if (tk) k++;
    end
    total++;
    if (t17 - t1 != (FRAC_ON ? 168 : 160)) begin
      bad++;
      $display("FAIL frac_span got=%0d want=%0d", t17 - t1, FRAC_ON ? 168 : 160);
    end
  endtask

  task automatic test_deferred();
    int exp_t[7] = '{10, 15, 20, 25, 30, 37, 44};
    int idx;
    bit tk, ep;
    logic [PW+2:0] e;
    div_frac = '0;
    do_load(10, 0);
    do_clear();
    idx = 0;
    for (int t = 1; t <= 46; t++) begin
      div_load = 1'b0;
      if (t == 3)  begin div_int = 3; div_load = 1'b1; end
      if (t == 4)  begin div_int = 5; div_load = 1'b1; end
      if (t == 25) begin div_int = 7; div_load = 1'b1; end
      tick_edge();
      tk = (idx < 7) && (t == exp_t[idx]);
      ep = (t >= 3 && t < 10) || (t >= 25 && t < 30);
      e  = pack_exp(tk, tk ? (idx + 1) % OVS : idx % OVS);
      total++;
      if (obs !== e || div_pending !== ep) begin
        bad++;
        $display("FAIL deferred t=%0d got=%b/%b want=%b/%b", t, obs, div_pending, e, ep);
      end
      if (tk) idx++;
    end
    div_load = 1'b0;
  endtask

  task automatic test_sync_clear();
    bit tk;
    logic [PW+2:0] e;
    do_load(10, 0);
    do_clear();
    for (int t = 1; t <= 16; t++) tick_edge();
    total++;
    if (os_phase !== PW'(1)) begin
      bad++;
      $display("FAIL preclear_phase got=%0d want=1", os_phase);
    end
    do_clear();
    total++;
    if (obs !== pack_exp(0, 0)) begin
      bad++;
      $display("FAIL midclear got=%b want=%b", obs, pack_exp(0, 0));
    end
    for (int t = 1; t <= 12; t++) begin
      tick_edge();
      tk = (t == 10);
      e  = pack_exp(tk, t >= 10 ? 1 : 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL after_clear t=%0d got=%b want=%b", t, obs, e);
      end
    end
  endtask

  task automatic test_enable();
    int k, n_en;
    bit tk, ep;
    logic [PW+2:0] e;
    do_load(10, 0);
    do_clear();
    k = 1; n_en = 0; ep = 1'b0;
    for (int t = 1; t <= 90; t++) begin
      div_load = 1'b0;
      enable = (t > 4 && t <= 24) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (t == 12) begin div_int = 10; div_frac = 0; div_load = 1'b1; end
      tick_edge();
      if (t == 12) ep = 1'b1;
      if (enable) n_en++;
      tk = enable && (n_en % 10 == 0);
      if (tk && t > 12) ep = 1'b0;
      e = pack_exp(tk, tk ? k % OVS : (k - 1) % OVS);
      total++;
      if (obs !== e || div_pending !== ep) begin
        bad++;
        $display("FAIL enable t=%0d got=%b/%b want=%b/%b", t, obs, div_pending, e, ep);
      end
      if (tk) k++;
    end
    div_load = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_div_one_zero();
    logic [PW+2:0] e;
    do_load(1, 0);
    do_clear();
    for (int t = 1; t <= 20; t++) begin
      tick_edge();
      e = pack_exp(1'b1, t % OVS);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL div1 t=%0d got=%b want=%b", t, obs, e);
      end
    end
    do_load(0, 0);
    do_clear();
    total++;
    if (div_pending !== 1'b0) begin
      bad++;
      $display("FAIL div0_apply got=%b want=0", div_pending);
    end
    for (int t = 1; t <= 30; t++) begin
      tick_edge();
      total++;
      if (obs !== pack_exp(0, 0)) begin
        bad++;
        $display("FAIL div0 t=%0d got=%b want=%b", t, obs, pack_exp(0, 0));
      end
    end
  endtask

  task automatic test_random();
    int d, f, fe, k, lim;
    bit tk;
    logic [PW+2:0] e;
    for (int it = 0; it < 5; it++) begin
      d  = $urandom_range(2, 12);
      f  = $urandom_range(0, 15);
      fe = FRAC_ON ? f : 0;
      do_load(d, f);
      do_clear();
      k = 1;
      lim = d * (OVS + 2) + OVS + 2;
      for (int t = 1; t <= lim; t++) begin
        tick_edge();
        tk = (t == tick_time(k, d, fe));
        e  = pack_exp(tk, tk ? k % OVS : (k - 1) % OVS);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL random d=%0d f=%0d t=%0d got=%b want=%b", d, f, t, obs, e);
        end
        if (tk) k++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_clear();
    test_frac();
    test_deferred();
    test_sync_clear();
    test_enable();
    test_div_one_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
